// File: rtl/wavetable_oscillator_if.sv
// Oscillator-side bundle: sample request/frequency controls, wavetable RAM port and sample output.
interface wavetable_oscillator_if #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16
);
    logic               SampleTick;
    logic [PHASE_W-1:0] PhaseInc;
    logic               PhaseSync;
    logic [ADDR_W-1:0]  Addr;
    logic [DATA_W-1:0]  RamData;
    logic [DATA_W-1:0]  SampleOut;
    logic               SampleValid;
    logic               Busy;
    logic               Overrun;

    modport master (
        output SampleTick, PhaseInc, PhaseSync, RamData,
        input  Addr, SampleOut, SampleValid, Busy, Overrun
    );

    modport slave (
        input  SampleTick, PhaseInc, PhaseSync, RamData,
        output Addr, SampleOut, SampleValid, Busy, Overrun
    );
endinterface

// File: rtl/wavetable_oscillator.sv
// Phase-accumulator wavetable oscillator: fetches entries idx and idx+1, linearly interpolates by frac.
// Latency: SampleValid pulses 4 cycles after the accepted SampleTick edge.
// No backpressure: ticks arriving while Busy are dropped and flagged on sticky Overrun.
module wavetable_oscillator #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 12,
    parameter int FRAC_W  = 8,
    parameter int DATA_W  = 16
) (
    input logic                   Clk,
    input logic                   Reset,
    wavetable_oscillator_if.slave osc
);
    localparam int PROD_W = DATA_W + FRAC_W + 2;

    typedef enum logic [2:0] {IDLE, ADDR_A, ADDR_B, CAP_B, CALC} state_t;

    state_t              state, next_state;
    logic [PHASE_W-1:0]  phase, inc;
    logic [ADDR_W-1:0]   idx, addr;
    logic [FRAC_W-1:0]   frac;
    logic [DATA_W-1:0]   a_smp, b_smp, sample, interp;
    logic                valid, overrun, pend_sync;
    logic                busy, start, sync_now;
    logic signed [PROD_W-1:0] a_x, b_x, f_x, prod;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (osc.SampleTick) next_state = ADDR_A;
            ADDR_A:  next_state = ADDR_B;
            ADDR_B:  next_state = CAP_B;
            CAP_B:   next_state = CALC;
            CALC:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        start = (state == IDLE) && osc.SampleTick;
    end

    assign sync_now = osc.PhaseSync | pend_sync;

    // Full-width signed product keeps (B-A)*frac exact; >>> floors toward -inf.
    assign a_x    = {{(PROD_W-DATA_W){a_smp[DATA_W-1]}}, a_smp};
    assign b_x    = {{(PROD_W-DATA_W){b_smp[DATA_W-1]}}, b_smp};
    assign f_x    = {{(PROD_W-FRAC_W){1'b0}}, frac};
    assign prod   = (b_x - a_x) * f_x;
    assign interp = a_smp + DATA_W'(prod >>> FRAC_W);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            phase     <= '0;
            inc       <= '0;
            idx       <= '0;
            frac      <= '0;
            addr      <= '0;
            a_smp     <= '0;
            b_smp     <= '0;
            sample    <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            pend_sync <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (busy && osc.SampleTick) overrun <= 1'b1;
            if (osc.PhaseSync) pend_sync <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        inc       <= osc.PhaseInc;
                        pend_sync <= 1'b0;
                        if (sync_now) begin
                            phase <= '0;
                            idx   <= '0;
                            frac  <= '0;
                            addr  <= '0;
                        end else begin
                            idx  <= phase[PHASE_W-1 -: ADDR_W];
                            frac <= phase[PHASE_W-ADDR_W-1 -: FRAC_W];
                            addr <= phase[PHASE_W-1 -: ADDR_W];
                        end
                    end
                end
                ADDR_A: addr  <= idx + ADDR_W'(1);
                ADDR_B: a_smp <= osc.RamData;
                CAP_B:  b_smp <= osc.RamData;
                CALC: begin
                    sample    <= interp;
                    valid     <= 1'b1;
                    phase     <= sync_now ? '0 : phase + inc;
                    pend_sync <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign osc.Addr        = addr;
    assign osc.SampleOut   = sample;
    assign osc.SampleValid = valid;
    assign osc.Busy        = busy;
    assign osc.Overrun     = overrun;
endmodule

// File: tb/tb_wavetable_oscillator.sv
// Bench for wavetable_oscillator: behavioural RAM, phase model and scoreboard of expected samples.
module tb_wavetable_oscillator;
    localparam int PHASE_W = 32;
    localparam int ADDR_W  = 12;
    localparam int FRAC_W  = 8;
    localparam int DATA_W  = 16;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    wavetable_oscillator_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) osc ();

    wavetable_oscillator #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .osc   (osc)
    );

    logic [DATA_W-1:0] tbl [0:4095];
    always @(posedge Clk) osc.RamData <= tbl[osc.Addr];

    typedef struct { int value; int cyc; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] m_phase;
    bit m_pend;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int tbl_val(input int i);
        logic signed [DATA_W-1:0] v;
        v = tbl[i];
        return int'(v);
    endfunction

    function automatic int interp_ref(input int a, input int b, input int f);
        int d;
        d = (b - a) * f;
        if (d >= 0) return a + d / 256;
        return a - ((-d + 255) / 256);
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < 4096; i++) tbl[i] = 16'(8 * i);
    endtask

    // Called just after a falling edge; returns one falling edge later.
    task automatic tick(input logic [31:0] inc, input bit sync);
        exp_t e;
        int idx, f;
        osc.SampleTick = 1'b1;
        osc.PhaseInc   = inc;
        osc.PhaseSync  = sync;
        if (sync || m_pend) begin
            m_phase = 32'h0;
            m_pend  = 1'b0;
        end
        idx = int'(m_phase[31:20]);
        f   = int'(m_phase[19:12]);
        e.value = interp_ref(tbl_val(idx), tbl_val((idx + 1) % 4096), f);
        e.cyc   = cyc + 5;
        sb.push_back(e);
        m_phase = m_phase + inc;
        @(negedge Clk);
        osc.SampleTick = 1'b0;
        osc.PhaseSync  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d samples outstanding expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset && osc.SampleValid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid got SampleOut=%0d at cycle %0d expected no sample",
                         $signed(osc.SampleOut), cyc);
            end else begin
                mon_e = sb.pop_front();
                if (int'($signed(osc.SampleOut)) !== mon_e.value) begin
                    errors++;
                    $display("FAIL sample_value got %0d expected %0d", $signed(osc.SampleOut), mon_e.value);
                end
                checks++;
                if (cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL sample_latency got cycle %0d expected cycle %0d", cyc, mon_e.cyc);
                end
                checks++;
                if (osc.Busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_valid got %b expected 0", osc.Busy);
                end
            end
        end
    end

    task automatic test_reset();
        Reset = 1'b1;
        osc.SampleTick = 1'b0;
        osc.PhaseSync  = 1'b0;
        osc.PhaseInc   = 32'h0;
        m_phase = 32'h0;
        m_pend  = 1'b0;
        repeat (3) @(negedge Clk);
        checks += 5;
        if (osc.Addr !== 12'd0) begin errors++; $display("FAIL reset_addr got %0d expected 0", osc.Addr); end
        if (osc.SampleOut !== 16'd0) begin errors++; $display("FAIL reset_sample got %0d expected 0", osc.SampleOut); end
        if (osc.SampleValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", osc.SampleValid); end
        if (osc.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", osc.Busy); end
        if (osc.Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b expected 0", osc.Overrun); end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 4; i++) begin
            tick(32'h0010_0000, 1'b0);
            if (i == 0) begin
                checks++;
                if (osc.Busy !== 1'b1) begin errors++; $display("FAIL ramp_busy got %b expected 1", osc.Busy); end
            end
            repeat (9) @(negedge Clk);
        end
        wait_drain("ramp");
    endtask

    task automatic test_half();
        tick(32'h0008_0000, 1'b1);
        repeat (9) @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            tick(32'h0008_0000, 1'b0);
            repeat (9) @(negedge Clk);
        end
        wait_drain("half");
    endtask

    task automatic test_wrap();
        tbl[4095] = 16'd1000;
        tbl[0]    = 16'hFC18;
        tick(32'hFFF8_0000, 1'b1);
        repeat (9) @(negedge Clk);
        tick(32'h0008_0000, 1'b0);
        checks++;
        if (osc.Addr !== 12'd4095) begin errors++; $display("FAIL wrap_addr_a got %0d expected 4095", osc.Addr); end
        @(negedge Clk);
        checks++;
        if (osc.Addr !== 12'd0) begin errors++; $display("FAIL wrap_addr_b got %0d expected 0", osc.Addr); end
        repeat (8) @(negedge Clk);
        tick(32'h0008_0000, 1'b0);
        repeat (9) @(negedge Clk);
        wait_drain("wrap");
        fill_ramp();
    endtask

    task automatic test_back_to_back();
        tick(32'h0010_0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            osc.PhaseInc = 32'h1234_5678;
            repeat (4) @(negedge Clk);
            tick(32'h0010_0000, 1'b0);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_overrun();
        checks++;
        if (osc.Overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre got %b expected 0", osc.Overrun); end
        tick(32'h0010_0000, 1'b0);
        @(negedge Clk);
        osc.SampleTick = 1'b1;
        @(negedge Clk);
        osc.SampleTick = 1'b0;
        checks++;
        if (osc.Overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b expected 1", osc.Overrun); end
        wait_drain("overrun");
        repeat (10) @(negedge Clk);
        checks++;
        if (osc.Overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b expected 1", osc.Overrun); end
    endtask

    task automatic test_sync();
        tick(32'h0010_0000, 1'b1);
        repeat (9) @(negedge Clk);
        tick(32'h0010_0000, 1'b0);
        repeat (9) @(negedge Clk);
        tick(32'h0010_0000, 1'b0);
        osc.PhaseSync = 1'b1;
        m_pend = 1'b1;
        @(negedge Clk);
        osc.PhaseSync = 1'b0;
        repeat (8) @(negedge Clk);
        tick(32'h0010_0000, 1'b0);
        repeat (9) @(negedge Clk);
        wait_drain("sync");
        checks++;
        if (osc.Overrun !== 1'b1) begin errors++; $display("FAIL sync_overrun_sticky got %b expected 1", osc.Overrun); end
    endtask

    task automatic test_reset_mid();
        tick(32'h0010_0000, 1'b0);
        repeat (9) @(negedge Clk);
        wait_drain("pre_reset");
        tick(32'h0010_0000, 1'b0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        checks += 5;
        if (osc.Addr !== 12'd0) begin errors++; $display("FAIL midreset_addr got %0d expected 0", osc.Addr); end
        if (osc.SampleOut !== 16'd0) begin errors++; $display("FAIL midreset_sample got %0d expected 0", osc.SampleOut); end
        if (osc.SampleValid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b expected 0", osc.SampleValid); end
        if (osc.Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b expected 0", osc.Busy); end
        if (osc.Overrun !== 1'b0) begin errors++; $display("FAIL midreset_overrun got %b expected 0", osc.Overrun); end
        sb.delete();
        m_phase = 32'h0;
        m_pend  = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        tick(32'h0010_0000, 1'b0);
        repeat (9) @(negedge Clk);
        wait_drain("post_reset");
    endtask

    initial begin
        fill_ramp();
        test_reset();
        test_ramp();
        test_half();
        test_wrap();
        test_back_to_back();
        test_overrun();
        test_sync();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion expected finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
